// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller and the data memory.
//   master : controller side (drives address, write data, size, rw, enable)
//   slave  : memory side (drives busy and read data)
// Signals:
//   mem_address      word-aligned byte address
//   mem_data_in      write word toward memory
//   mem_access_size  access size code, 2'b00 = word
//   mem_rw           1 = read, 0 = write
//   mem_enable       request valid
//   mem_busy         access not finished; completes when enable=1 and busy=0
//   mem_data_out     read word, big-endian, valid in the completing cycle
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [1:0]        mem_access_size;
  logic              mem_rw;
  logic              mem_enable;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    input  mem_busy, mem_data_out
  );

  modport slave (
    input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    output mem_busy, mem_data_out
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller sitting between the X/M pipeline register and the
// data memory. Decodes load/store opcodes, runs word-wide memory accesses
// (read-modify-write for sb/sh), extends load results and reports alignment
// faults. stall_out freezes F/D, D/X and X/M while an access is in flight.
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   in_valid       X/M holds a live instruction
//   in_insn        IR_XM, opcode in [31:26]
//   in_addr        effective byte address
//   in_wdata       store data
//   mem            data-memory bus (master side)
//   stall_out      freeze upstream stages and X/M
//   out_valid      one-cycle pulse when a load/store retires
//   out_data       extended load value, 0 for stores and faults
//   misalign       one-cycle pulse alongside out_valid on an alignment fault
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_insn,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]    in_wdata,
  mem_stage_ctrl_if.master     mem,
  output logic                 stall_out,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 misalign
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  state_t            state;
  logic              mem_enable_r;
  logic              mem_rw_r;
  logic [DATA_W-1:0] mem_data_in_r;

  // Operands captured when the access leaves IDLE; X/M may change afterwards.
  logic [ADDR_W-1:0] addr_p1;
  logic [5:0]        op_p1;
  logic [15:0]       wdata_p1;

  logic [5:0] op;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       bad_align;
  logic       unused_insn;

  // Pick the addressed byte/half (big-endian lanes) and extend it.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [5:0]        opc,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] word
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  r;
    unique case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    unique case (opc)
      OP_LB:   r = DATA_W'(b);
      OP_LBU:  r = {{(DATA_W-8){1'b0}}, b};
      OP_LH:   r = DATA_W'(h);
      OP_LHU:  r = {{(DATA_W-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the target byte/half lane of the read word with the store data.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [5:0]        opc,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] word,
    input logic [15:0]       wd
  );
    logic [DATA_W-1:0] r;
    r = word;
    if (opc == OP_SB) begin
      unique case (lane)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[15:0] = wd;
    end else begin
      r[31:16] = wd;
    end
    return r;
  endfunction

  // Only the opcode field matters here; the rest of IR_XM is consumed elsewhere.
  assign unused_insn = ^in_insn[25:0];

  always_comb begin
    op        = in_insn[31:26];
    is_load   = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                (op == OP_LB) || (op == OP_LBU);
    is_store  = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    is_mem    = is_load || is_store;
    bad_align = (((op == OP_LW) || (op == OP_SW)) && (in_addr[1:0] != 2'b00)) ||
                (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && in_addr[0]);
  end

  // A misaligned op is not stalled: it retires from DONE without touching memory.
  assign stall_out = ((state != IDLE) && (state != DONE)) ||
                     ((state == IDLE) && in_valid && is_mem && !bad_align);

  assign mem.mem_address     = {addr_p1[ADDR_W-1:2], 2'b00};
  assign mem.mem_data_in     = mem_data_in_r;
  assign mem.mem_access_size = 2'b00;
  assign mem.mem_rw          = mem_rw_r;
  assign mem.mem_enable      = mem_enable_r;

  // ---- X/M -> access stage: operand capture ----
  always_ff @(posedge clock) begin
    if ((state == IDLE) && in_valid) begin
      addr_p1  <= in_addr;
      op_p1    <= op;
      wdata_p1 <= in_wdata[15:0];
    end
  end

  // ---- access stage -> M/W: sequencing and registered outputs ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mem_enable_r  <= 1'b0;
      mem_rw_r      <= 1'b1;
      mem_data_in_r <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      misalign      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && is_mem) begin
            if (bad_align) begin
              state     <= DONE;
              out_valid <= 1'b1;
              misalign  <= 1'b1;
              out_data  <= '0;
            end else if (is_load) begin
              state        <= RD;
              mem_enable_r <= 1'b1;
              mem_rw_r     <= 1'b1;
            end else if (op == OP_SW) begin
              state         <= WR;
              mem_enable_r  <= 1'b1;
              mem_rw_r      <= 1'b0;
              mem_data_in_r <= in_wdata;
            end else begin
              state        <= RMW_RD;
              mem_enable_r <= 1'b1;
              mem_rw_r     <= 1'b1;
            end
          end
        end
        RD: begin
          if (!mem.mem_busy) begin
            state        <= DONE;
            mem_enable_r <= 1'b0;
            out_valid    <= 1'b1;
            out_data     <= load_extend(op_p1, addr_p1[1:0], mem.mem_data_out);
          end
        end
        RMW_RD: begin
          // Enable stays high straight into the write half of the RMW.
          if (!mem.mem_busy) begin
            state         <= RMW_WR;
            mem_rw_r      <= 1'b0;
            mem_data_in_r <= store_merge(op_p1, addr_p1[1:0], mem.mem_data_out, wdata_p1);
          end
        end
        WR, RMW_WR: begin
          if (!mem.mem_busy) begin
            state        <= DONE;
            mem_enable_r <= 1'b0;
            mem_rw_r     <= 1'b1;
            out_valid    <= 1'b1;
            out_data     <= '0;
          end
        end
        DONE: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          misalign  <= 1'b0;
          out_data  <= '0;
        end
        default: begin
          state        <= IDLE;
          mem_enable_r <= 1'b0;
          mem_rw_r     <= 1'b1;
        end
      endcase
    end
  end

endmodule
